// File: rtl/crypt_dma_pkg.sv
// Shared widths, read-side state encoding and operation codes for the crypto DMA stage.
package crypt_dma_pkg;

  localparam int DEF_AW = 13;
  localparam int DEF_DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_DRAIN,
    ST_DONE
  } dma_state_e;

  localparam logic [1:0] CMD_ENC  = 2'b00;
  localparam logic [1:0] CMD_DEC  = 2'b01;
  localparam logic [1:0] CMD_HASH = 2'b10;
  localparam logic [1:0] CMD_RSV  = 2'b11;

endpackage

// File: rtl/dma_addr_ctr.sv
// Base register plus word-offset counter; the address output wraps modulo 2^AW.
module dma_addr_ctr
  import crypt_dma_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] cnt,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] base_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      cnt    <= '0;
    end else if (load) begin
      base_q <= base;
      cnt    <= '0;
    end else if (inc) begin
      cnt <= cnt + AW'(1);
    end
  end

  assign addr = base_q + cnt;

endmodule

// File: rtl/crypt_dma_ctrl.sv
// Moves BSR words SRAM -> crypto core -> SRAM; write side runs alongside the read FSM.
module crypt_dma_ctrl
  import crypt_dma_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          AHB_HCLK,
  input  logic          AHB_HRESETN,
  input  logic          ENABLE,
  input  logic [1:0]    CMDR,
  input  logic [AW-1:0] SAR_ADDR,
  input  logic [AW-1:0] DAR_ADDR,
  input  logic [AW-1:0] BSR,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_RE,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          CORE_START,
  output logic [1:0]    CORE_MODE,
  output logic          CORE_IN_VALID,
  input  logic          CORE_IN_READY,
  output logic [DW-1:0] CORE_IN_DATA,
  input  logic          CORE_OUT_VALID,
  output logic          CORE_OUT_READY,
  input  logic [DW-1:0] CORE_OUT_DATA,
  output logic          SET_STR,
  output logic          BUSY
);

  dma_state_e    state;
  logic          enable_q;
  logic          busy_q;
  logic          set_str_q;
  logic          core_start_q;
  logic [1:0]    mode_q;
  logic [AW-1:0] bsr_q;
  logic [DW-1:0] hold;
  logic [AW-1:0] rcnt, wcnt, rd_addr, wr_addr;
  logic          start, idle_start, abort, wr_fire;

  assign start      = ENABLE && !enable_q;
  assign idle_start = start && (state == ST_IDLE);
  assign abort      = !ENABLE && busy_q;

  assign CORE_OUT_READY = busy_q && (wcnt < bsr_q);
  assign wr_fire        = CORE_OUT_VALID && CORE_OUT_READY;

  // A write steals the SRAM port; FETCH simply re-issues its read next cycle.
  assign MEM_WE    = wr_fire;
  assign MEM_RE    = (state == ST_FETCH) && !wr_fire;
  assign MEM_ADDR  = wr_fire ? wr_addr : (MEM_RE ? rd_addr : '0);
  assign MEM_WDATA = wr_fire ? CORE_OUT_DATA : '0;

  assign CORE_IN_VALID = (state == ST_SEND);
  assign CORE_IN_DATA  = hold;
  assign CORE_START    = core_start_q;
  assign CORE_MODE     = mode_q;
  assign SET_STR       = set_str_q;
  assign BUSY          = busy_q;

  dma_addr_ctr #(.AW(AW)) u_rd_ctr (
    .clk   (AHB_HCLK),
    .rst_n (AHB_HRESETN),
    .load  (idle_start),
    .inc   (state == ST_LOAD),
    .base  (SAR_ADDR),
    .cnt   (rcnt),
    .addr  (rd_addr)
  );

  dma_addr_ctr #(.AW(AW)) u_wr_ctr (
    .clk   (AHB_HCLK),
    .rst_n (AHB_HRESETN),
    .load  (idle_start),
    .inc   (wr_fire),
    .base  (DAR_ADDR),
    .cnt   (wcnt),
    .addr  (wr_addr)
  );

  always_ff @(posedge AHB_HCLK or negedge AHB_HRESETN) begin
    if (!AHB_HRESETN) begin
      state        <= ST_IDLE;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      set_str_q    <= 1'b0;
      core_start_q <= 1'b0;
      mode_q       <= '0;
      bsr_q        <= '0;
      hold         <= '0;
    end else begin
      enable_q     <= ENABLE;
      core_start_q <= 1'b0;
      set_str_q    <= 1'b0;
      if (abort) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              bsr_q  <= BSR;
              mode_q <= CMDR;
              // Reserved and empty jobs finish from IDLE without ever raising BUSY.
              if (CMDR == CMD_RSV) begin
                set_str_q <= 1'b1;
              end else if (BSR == '0) begin
                core_start_q <= 1'b1;
                set_str_q    <= 1'b1;
              end else begin
                core_start_q <= 1'b1;
                busy_q       <= 1'b1;
                state        <= ST_FETCH;
              end
            end
          end
          ST_FETCH: if (!wr_fire) state <= ST_LOAD;
          ST_LOAD: begin
            hold  <= MEM_RDATA;
            state <= ST_SEND;
          end
          ST_SEND: if (CORE_IN_READY) state <= (rcnt < bsr_q) ? ST_FETCH : ST_DRAIN;
          ST_DRAIN: begin
            if (wcnt == bsr_q) begin
              state     <= ST_DONE;
              busy_q    <= 1'b0;
              set_str_q <= 1'b1;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crypt_dma_ctrl.sv
// Directed bench: SRAM and inverting-core models around crypt_dma_ctrl.
module tb_crypt_dma_ctrl;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [1:0]    cmdr;
  logic [AW-1:0] sar, dar, bsr;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          core_start;
  logic [1:0]    core_mode;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          set_str, busy;

  always #5 clk = ~clk;

  crypt_dma_ctrl #(.AW(AW), .DW(DW)) dut (
    .AHB_HCLK       (clk),
    .AHB_HRESETN    (rst_n),
    .ENABLE         (enable),
    .CMDR           (cmdr),
    .SAR_ADDR       (sar),
    .DAR_ADDR       (dar),
    .BSR            (bsr),
    .MEM_ADDR       (mem_addr),
    .MEM_RE         (mem_re),
    .MEM_WE         (mem_we),
    .MEM_WDATA      (mem_wdata),
    .MEM_RDATA      (mem_rdata),
    .CORE_START     (core_start),
    .CORE_MODE      (core_mode),
    .CORE_IN_VALID  (in_valid),
    .CORE_IN_READY  (in_ready),
    .CORE_IN_DATA   (in_data),
    .CORE_OUT_VALID (out_valid),
    .CORE_OUT_READY (out_ready),
    .CORE_OUT_DATA  (out_data),
    .SET_STR        (set_str),
    .BUSY           (busy)
  );

  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    return {3'b101, a, 3'b010, a};
  endfunction

  // SRAM: unwritten words read back as pat(addr).
  logic [DW-1:0] wmem [0:8191];
  logic [8191:0] wvalid;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wvalid <= '0;
    end else begin
      if (mem_we) begin
        wmem[mem_addr]   <= mem_wdata;
        wvalid[mem_addr] <= 1'b1;
      end
      if (mem_re) mem_rdata <= wvalid[mem_addr] ? wmem[mem_addr] : pat(mem_addr);
    end
  end

  // Core: returns each accepted input word inverted, in order.
  logic [DW-1:0] cq [$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq.delete();
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) void'(cq.pop_front());
      if (in_valid && in_ready) cq.push_back(~in_data);
      out_valid <= (cq.size() > 0);
      out_data  <= (cq.size() > 0) ? cq[0] : '0;
    end
  end

  int unsigned   cyc = 0, n_re = 0, n_we = 0, n_ss = 0, n_cs = 0, last_we_cyc = 0;
  logic          both_seen = 1'b0;
  logic [AW-1:0] rd_log [$];
  logic [AW-1:0] wr_log [$];
  always @(posedge clk) begin
    if (mem_re) begin n_re++; rd_log.push_back(mem_addr); end
    if (mem_we) begin n_we++; wr_log.push_back(mem_addr); last_we_cyc = cyc; end
    if (set_str) n_ss++;
    if (core_start) n_cs++;
    if (mem_re && mem_we) both_seen = 1'b1;
    cyc++;
  end

  int n_tests = 0, n_fail = 0;
  int unsigned re_b, we_b, ss_b, cs_b, rdl_b, wrl_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW-1:0] n, input logic [1:0] c);
    re_b = n_re; we_b = n_we; ss_b = n_ss; cs_b = n_cs;
    rdl_b = rd_log.size(); wrl_b = wr_log.size();
    sar = s; dar = d; bsr = n; cmdr = c;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic finish_job(input string tag);
    logic found, pr, pb;
    int unsigned ss_cyc;
    found = 1'b0; pr = 1'b0; pb = 1'b0; ss_cyc = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (set_str) begin
        found  = 1'b1;
        ss_cyc = cyc;
      end else begin
        pr = out_ready;
        pb = busy;
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, found, 1'b1);
    chk({tag, "_done_latency"}, ss_cyc - last_we_cyc, 2);
    chk({tag, "_drain_busy_ready"}, {pb, pr}, 2'b10);
    @(negedge clk);
    chk({tag, "_setstr_pulse"}, set_str, 1'b0);
    chk({tag, "_busy_after"}, busy, 1'b0);
    repeat (2) @(negedge clk);
    chk({tag, "_no_restart"}, n_cs - cs_b, 1);
    chk({tag, "_setstr_count"}, n_ss - ss_b, 1);
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_job(input string tag, input logic [AW-1:0] s,
                           input logic [AW-1:0] d, input int n);
    logic [AW-1:0] sa, da;
    chk({tag, "_reads"}, n_re - re_b, n);
    chk({tag, "_writes"}, n_we - we_b, n);
    for (int i = 0; i < n; i++) begin
      sa = s + AW'(i);
      da = d + AW'(i);
      chk({tag, "_rd_addr"}, rd_log[rdl_b + i], sa);
      chk({tag, "_wr_addr"}, wr_log[wrl_b + i], da);
      chk({tag, "_wr_valid"}, wvalid[da], 1'b1);
      chk({tag, "_wr_data"}, wmem[da], ~pat(sa));
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_ready = 1'b1;
    cmdr = '0; sar = '0; dar = '0; bsr = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_set_str", set_str, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_out_ready", out_ready, 1'b0);
    chk("rst_in_valid", in_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic job with start timing, collision and live-register checks
    start_job(13'h010, 13'h100, 13'd4, 2'b00);
    chk("basic_start_pulse", core_start, 1'b1);
    chk("basic_start_busy", busy, 1'b1);
    chk("basic_start_re", mem_re, 1'b1);
    chk("basic_start_addr", mem_addr, 13'h010);
    sar = 13'h0555; dar = 13'h0777; bsr = 13'd9; cmdr = 2'b11;
    @(negedge clk);
    chk("basic_load_pulse", core_start, 1'b0);
    chk("basic_load_re", mem_re, 1'b0);
    @(negedge clk);
    chk("basic_send_valid", in_valid, 1'b1);
    chk("basic_send_data", in_data, pat(13'h010));
    @(negedge clk);
    chk("coll_we", mem_we, 1'b1);
    chk("coll_re", mem_re, 1'b0);
    chk("coll_addr", mem_addr, 13'h100);
    chk("coll_wdata", mem_wdata, ~pat(13'h010));
    @(negedge clk);
    chk("coll_retry_re", mem_re, 1'b1);
    chk("coll_retry_addr", mem_addr, 13'h011);
    finish_job("basic");
    check_job("basic", 13'h010, 13'h100, 4);
    chk("basic_mode", core_mode, 2'b00);

    // Wrap-around with input back-pressure, in place at 0x1FFE
    in_ready = 1'b0;
    start_job(13'h1FFE, 13'h1FFE, 13'd3, 2'b01);
    chk("wrap_first_addr", mem_addr, 13'h1FFE);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", in_valid, 1'b1);
      chk("bp_data", in_data, pat(13'h1FFE));
      chk("bp_reads", n_re - re_b, 1);
      if (i < 4) @(negedge clk);
    end
    in_ready = 1'b1;
    finish_job("wrap");
    check_job("wrap", 13'h1FFE, 13'h1FFE, 3);
    chk("wrap_mode", core_mode, 2'b01);

    // Empty job
    start_job(13'h010, 13'h600, 13'd0, 2'b00);
    chk("empty_set_str", set_str, 1'b1);
    chk("empty_core_start", core_start, 1'b1);
    chk("empty_busy", busy, 1'b0);
    @(negedge clk);
    chk("empty_set_str_off", set_str, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    chk("empty_no_mem", (n_re - re_b) + (n_we - we_b), 0);

    // Reserved operation code
    start_job(13'h010, 13'h600, 13'd4, 2'b11);
    chk("rsv_set_str", set_str, 1'b1);
    chk("rsv_core_start", core_start, 1'b0);
    chk("rsv_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("rsv_no_mem", (n_re - re_b) + (n_we - we_b), 0);
    chk("rsv_no_start", n_cs - cs_b, 0);
    chk("rsv_set_str_count", n_ss - ss_b, 1);
    enable = 1'b0;
    @(negedge clk);

    // Abort after two words, then a full job
    start_job(13'h020, 13'h200, 13'd4, 2'b10);
    for (int k = 0; k < 100 && (n_we - we_b) < 2; k++) @(negedge clk);
    chk("abort_two_writes", n_we - we_b, 2);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_valid", in_valid, 1'b0);
    repeat (5) @(negedge clk);
    chk("abort_no_set_str", n_ss - ss_b, 0);
    chk("abort_writes_final", n_we - we_b, 2);
    chk("abort_third_unwritten", wvalid[13'h202], 1'b0);
    start_job(13'h040, 13'h300, 13'd2, 2'b00);
    finish_job("post_abort");
    check_job("post_abort", 13'h040, 13'h300, 2);

    // Reset mid-job, then a full job
    start_job(13'h060, 13'h400, 13'd3, 2'b00);
    chk("prerst_re", mem_re, 1'b1);
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("midrst_re", mem_re, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_core_start", core_start, 1'b0);
    chk("midrst_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_set_str", n_ss - ss_b, 0);
    start_job(13'h080, 13'h500, 13'd3, 2'b00);
    finish_job("post_rst");
    check_job("post_rst", 13'h080, 13'h500, 3);

    chk("re_we_exclusive", both_seen, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crypt_dma_ctrl.md
# crypt_dma_ctrl

Data-mover stage between the AHB register block and the crypto core. It consumes the programmed `ENABLE`, `CMDR`, `SAR_ADDR`, `DAR_ADDR` and `BSR` values, streams `BSR` 32-bit words from local SRAM at the source address into the core, and writes the core's output words back to SRAM at the destination address. When the last result word is written, it pulses `SET_STR` into the register block, which drives the status bit and the interrupt.

## Interface
- `AW`, 13: SRAM word-address width; also the width of `SAR_ADDR`, `DAR_ADDR` and `BSR`.
- `DW`, 32: data word width.
- `AHB_HCLK`  in  1  sole clock.
- `AHB_HRESETN`  in  1  asynchronous, active-low reset.
- `ENABLE`  in  1  run request, level, from the enable register.
- `CMDR`  in  2  operation code (00 encrypt, 01 decrypt, 10 hash, 11 reserved).
- `SAR_ADDR`, `DAR_ADDR`  in  AW  source and destination start word addresses.
- `BSR`  in  AW  transfer length in words; 0 means an empty job.
- `MEM_ADDR`  out  AW  SRAM address.
- `MEM_RE`, `MEM_WE`  out  1  SRAM read and write strobes; never both high in the same cycle.
- `MEM_WDATA`  out  DW  write data.
- `MEM_RDATA`  in  DW  read data, valid exactly 1 cycle after `MEM_RE`.
- `CORE_START`  out  1  one-cycle pulse at job start.
- `CORE_MODE`  out  2  `CMDR` value latched at job start.
- `CORE_IN_VALID`  out  1  / `CORE_IN_READY`  in  1  / `CORE_IN_DATA`  out  DW  input stream to the core.
- `CORE_OUT_VALID`  in  1  / `CORE_OUT_READY`  out  1  / `CORE_OUT_DATA`  in  DW  output stream from the core.
- `SET_STR`  out  1  one-cycle done pulse.
- `BUSY`  out  1  high from job start until `SET_STR` or abort.

## Operation
- **Reset.** Every output is 0. State is IDLE. Both counters, the latched addresses/length/mode, the hold buffer and `enable_q` are cleared.
- **Start.** A job starts on a rising edge of `ENABLE`, detected as `ENABLE && !enable_q`. On start the block latches `SAR_ADDR`, `DAR_ADDR`, `BSR` and `CMDR`, and clears `rcnt` and `wcnt`. A steady-high `ENABLE` never restarts a job.
- **Reserved code.** If `CMDR` = 11 at start, no job runs: `SET_STR` pulses on the next cycle with no memory or core traffic.
- **Empty job.** If `BSR` = 0 at start: the next cycle carries the `CORE_START` and `SET_STR` pulses, then IDLE. No memory access occurs.
- **Read FSM states:**
  - IDLE → FETCH on start.
  - FETCH: drive `MEM_RE`=1 and `MEM_ADDR`=`sar + rcnt`, then go to LOAD. If a write happens this cycle (see collision rule), FETCH stalls and `MEM_RE`=0.
  - LOAD: capture `MEM_RDATA` into the hold buffer, `rcnt`++, go to SEND.
  - SEND: `CORE_IN_VALID`=1 and `CORE_IN_DATA`=hold. On `CORE_IN_READY`, go to FETCH if `rcnt` < `bsr`, otherwise DRAIN.
  - DRAIN: wait until `wcnt` == `bsr`, then go to DONE.
  - DONE: `SET_STR`=1 for one cycle, `BUSY`=0, go to IDLE.
- **Write side.** It runs concurrently in every state except IDLE and DONE.
  - `CORE_OUT_READY` = `BUSY && wcnt < bsr`.
  - On a `CORE_OUT_VALID && CORE_OUT_READY` handshake, in the same cycle: `MEM_WE`=1, `MEM_ADDR`=`dar + wcnt`, `MEM_WDATA`=`CORE_OUT_DATA`, and `wcnt`++.
- **Collision rule.** A write has priority over a read; the FETCH read retries on the next cycle.
- **Address arithmetic.** Addresses are modulo 2^AW: `sar + rcnt` wraps from 0x1FFF to 0x0000, and the same applies to `dar + wcnt`. Counters are AW bits wide and compared unsigned.
- **Abort.** If `ENABLE` falls while `BUSY`, the next state is IDLE: no `SET_STR`, the in-flight core handshake is dropped, and `BUSY`=0 on the following cycle.
- **Live registers.** Changes to `SAR_ADDR`, `DAR_ADDR`, `BSR` or `CMDR` during a job are ignored.

## Timing
- **Start sequence** (start sampled at the edge ending cycle N):
  - cycle N+1: `CORE_START`=1, `BUSY`=1, `MEM_RE`=1.
  - cycle N+2: LOAD captures the data.
  - cycle N+3: `CORE_IN_VALID`=1.
- **Steady-state throughput:** 3 cycles per input word with an always-ready core and no collisions.
- **Hold buffer:** single entry. `CORE_IN_DATA` is stable while `CORE_IN_VALID` is high and not yet accepted.
- **Done:** the write of the last word occurs in cycle M; DRAIN exits at the end of M+1, and `SET_STR` is high in cycle M+2.
- **Reset mid-job:** all outputs fall asynchronously, with no `SET_STR`.

## Structure
- **Package `crypt_dma_pkg`:** the `AW`/`DW` defaults, the state enum (IDLE, FETCH, LOAD, SEND, DRAIN, DONE) and the `CMDR` localparams (ENC=2'b00, DEC=2'b01, HASH=2'b10, RSV=2'b11).
- **Sub-module `dma_addr_ctr`:** an AW-bit base register plus offset counter with a clear/increment interface and a modulo address output. It is instantiated twice, once for the read side and once for the write side.

## Test plan
- **Basic job:** `SAR_ADDR`=0x010, `DAR_ADDR`=0x100, `BSR`=4, `CMDR`=00, `ENABLE` 0→1, core echoes data XOR 0xFFFFFFFF → SRAM 0x100–0x103 hold the inverted words at 0x010–0x013; a single `SET_STR` pulse; `CORE_MODE`=00.
- **Wrap-around:** `SAR_ADDR`=0x1FFE, `BSR`=3 → reads at 0x1FFE, 0x1FFF, 0x0000; writes wrap the same way at the destination.
- **Collision:** core asserts `CORE_OUT_VALID` in the same cycle as FETCH → `MEM_WE`=1 and `MEM_RE`=0 that cycle, `MEM_RE`=1 on the next cycle; no word is lost or duplicated.
- **Back-pressure:** hold `CORE_IN_READY`=0 for 5 cycles in SEND → `CORE_IN_DATA` is stable and `rcnt` is unchanged; `CORE_OUT_READY`=0 after `wcnt`==`BSR`.
- **Empty and reserved jobs:** `BSR`=0 → `SET_STR` in cycle N+1, no `MEM_RE` or `MEM_WE`. `CMDR`=11 → `SET_STR` in N+1 and no `CORE_START`.
- **Abort and reset:** drop `ENABLE` after 2 words → IDLE, no `SET_STR`. Assert `AHB_HRESETN`=0 mid-job → all outputs 0 immediately. A new `ENABLE` rise after either runs a full job correctly.
